// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: pops the TX FIFO and serializes each byte LSB-first.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects odd).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
`ifdef UART_TX_PARITY_EN
  parameter bit PARITY_ODD   = 1'b0,
`endif
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1));
  assign cnt_nxt = bit_end ? '0 : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_nxt;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (enable && !fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        shift_d = fifo_rd_data;
        tx_d    = 1'b0;
        state_d = START;
`ifdef UART_TX_PARITY_EN
        par_d   = (^fifo_rd_data) ^ PARITY_ODD;
`endif
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          tx_d    = shift_d[0];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            idx_d      = '0;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: two instances (1 and 2 stop bits) against a
// frame-level reference model plus directed table and corner sequences.
module tb_uart_tx_ctrl;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME0 = (1 + 8 + 1 + PAR) * C;
  localparam int FRAME1 = (1 + 8 + 2 + PAR) * C;

  typedef struct packed {
    logic tx;
    logic rd;
    logic busy;
    logic fd;
  } ent_t;

  typedef struct {
    logic [7:0] data;
    logic [8:0] sym;
    logic       par_even;
  } vec_t;

  localparam ent_t IDLE_E = '{tx: 1'b1, rd: 1'b0, busy: 1'b0, fd: 1'b0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic emp [2];
  logic [7:0] rdd [2];
  logic rd_w [2];
  logic tx_w [2];
  logic busy_w [2];
  logic fd_w [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  ent_t exp0 [$];
  ent_t exp1 [$];
  ent_t cur0 = IDLE_E;
  ent_t cur1 = IDLE_E;

  logic lg_tx [256];
  logic lg_rd [256];
  logic lg_fd [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DATA_WIDTH(8),
    .CLKS_PER_BIT(C),
    .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rstn(rstn), .enable(enable),
    .fifo_empty(emp[0]), .fifo_rd_data(rdd[0]),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]),
    .busy(busy_w[0]), .frame_done(fd_w[0])
  );

  uart_tx_ctrl #(
    .DATA_WIDTH(8),
    .CLKS_PER_BIT(C),
`ifdef UART_TX_PARITY_EN
    .PARITY_ODD(1'b1),
`endif
    .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rstn(rstn), .enable(enable),
    .fifo_empty(emp[1]), .fifo_rd_data(rdd[1]),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .frame_done(fd_w[1])
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_ent(int i, ent_t e);
    if (i == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endfunction

  // Expected line activity for one frame, built from its symbol list.
  function automatic void sched(int i, logic [7:0] d);
    logic sym [$];
    int nstop;
    nstop = (i == 0) ? 1 : 2;
    sym.push_back(1'b0);
    for (int b = 0; b < 8; b++) sym.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    sym.push_back((^d) ^ (i == 1));
`endif
    for (int s = 0; s < nstop; s++) sym.push_back(1'b1);
    push_ent(i, '{tx: 1'b1, rd: 1'b1, busy: 1'b1, fd: 1'b0});
    push_ent(i, '{tx: 1'b1, rd: 1'b0, busy: 1'b1, fd: 1'b0});
    for (int s = 0; s < sym.size(); s++)
      for (int c = 0; c < C; c++)
        push_ent(i, '{tx: sym[s], rd: 1'b0, busy: 1'b1,
                      fd: (s == sym.size() - 1) && (c == C - 1)});
  endfunction

  function automatic void model_reset();
    exp0.delete();
    exp1.delete();
    cur0 = IDLE_E;
    cur1 = IDLE_E;
  endfunction

  function automatic void model_step(int i, logic en_s, logic e_s);
    ent_t c;
    c = (i == 0) ? cur0 : cur1;
    if (!c.busy && en_s && !e_s)
      sched(i, (i == 0) ? q0[0] : q1[0]);
    c = IDLE_E;
    if (i == 0 && exp0.size() > 0) c = exp0.pop_front();
    if (i == 1 && exp1.size() > 0) c = exp1.pop_front();
    if (i == 0) cur0 = c;
    else cur1 = c;
  endfunction

  // One clock: sample inputs, edge, FIFO/model update, compare.
  task automatic cyc();
    logic [1:0] r_s, e_s;
    logic en_s, rst_s;
    r_s = {rd_w[1], rd_w[0]};
    e_s = {emp[1], emp[0]};
    en_s = enable;
    rst_s = rstn;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      model_reset();
    end else begin
      model_step(0, en_s, e_s[0]);
      model_step(1, en_s, e_s[1]);
    end
    if (r_s[0] && q0.size() > 0) rdd[0] = q0.pop_front();
    if (r_s[1] && q1.size() > 0) rdd[1] = q1.pop_front();
    emp[0] = (q0.size() == 0);
    emp[1] = (q1.size() == 0);
    @(negedge clk);
    chk("scb_u0", int'({tx_w[0], rd_w[0], busy_w[0], fd_w[0]}), int'(cur0));
    chk("scb_u1", int'({tx_w[1], rd_w[1], busy_w[1], fd_w[1]}), int'(cur1));
  endtask

  task automatic run_log(int i, int lo, int hi);
    for (int k = lo; k <= hi; k++) begin
      cyc();
      lg_tx[k] = tx_w[i];
      lg_rd[k] = rd_w[i];
      lg_fd[k] = fd_w[i];
    end
  endtask

  function automatic logic ev(int w, int k);
    case (w)
      0: return !lg_tx[k];
      1: return lg_rd[k];
      default: return lg_fd[k];
    endcase
  endfunction

  function automatic int count_of(int w, int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (ev(w, k)) c++;
    return c;
  endfunction

  function automatic int nth_of(int w, int occ, int n);
    int c = 0;
    for (int k = 1; k <= n; k++)
      if (ev(w, k)) begin
        c++;
        if (c == occ) return k;
      end
    return -1;
  endfunction

  task automatic push(int i, logic [7:0] d);
    if (i == 0) q0.push_back(d);
    else q1.push_back(d);
    emp[i] = 1'b0;
  endtask

  task automatic areset();
    #1 rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_tx0", int'(tx_w[0]), 1);
    chk("arst_busy0", int'(busy_w[0]), 0);
    chk("arst_tx1", int'(tx_w[1]), 1);
    chk("arst_busy1", int'(busy_w[1]), 0);
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    vec_t tbl [5];
    int p1, p2, st;
    logic done;
    tbl[0] = '{data: 8'hA5, sym: 9'h14A, par_even: 1'b0};
    tbl[1] = '{data: 8'h3C, sym: 9'h078, par_even: 1'b0};
    tbl[2] = '{data: 8'h01, sym: 9'h002, par_even: 1'b1};
    tbl[3] = '{data: 8'h80, sym: 9'h100, par_even: 1'b1};
    tbl[4] = '{data: 8'h07, sym: 9'h00E, par_even: 1'b1};
    emp[0] = 1'b1;
    emp[1] = 1'b1;
    rdd[0] = '0;
    rdd[1] = '0;

    // Reset idle
    @(negedge clk);
    repeat (5) cyc();
    rstn = 1'b1;
    enable = 1'b1;
    run_log(0, 1, 50);
    chk("idle_tx_low", count_of(0, 50), 0);
    chk("idle_rd", count_of(1, 50), 0);
    chk("idle_busy", int'(busy_w[0]), 0);

    // Single-byte table on the 1-stop instance
    foreach (tbl[v]) begin
      push(0, tbl[v].data);
      run_log(0, 1, FRAME0 + 10);
      chk("rd_cnt", count_of(1, FRAME0 + 10), 1);
      chk("rd_at", nth_of(1, 1, FRAME0 + 10), 1);
      chk("start_at", nth_of(0, 1, FRAME0 + 10), 3);
      for (int s = 0; s < 9; s++)
        chk("sym", int'(lg_tx[3 + C * s + 2]), int'(tbl[v].sym[s]));
`ifdef UART_TX_PARITY_EN
      chk("par_even", int'(lg_tx[3 + C * 9 + 2]), int'(tbl[v].par_even));
`endif
      chk("stop", int'(lg_tx[3 + FRAME0 - 2]), 1);
      chk("fd_at", nth_of(2, 1, FRAME0 + 10), 3 + FRAME0 - 1);
      chk("fd_cnt", count_of(2, FRAME0 + 10), 1);
    end

    // Back-to-back on the 2-stop instance
    push(1, 8'h00);
    push(1, 8'hFF);
    run_log(1, 1, 120);
    p1 = nth_of(1, 1, 120);
    p2 = nth_of(1, 2, 120);
    chk("b2b_rd_cnt", count_of(1, 120), 2);
    chk("b2b_p1", p1, 1);
    chk("b2b_gap", p2 - p1, FRAME1 + 3);
    chk("b2b_fd_cnt", count_of(2, 120), 2);
    if (p2 > 0 && p2 + 2 + FRAME1 <= 120) begin
      for (int b = 0; b < 8; b++) begin
        chk("b2b_d0", int'(lg_tx[p1 + 2 + C * (b + 1) + 2]), 0);
        chk("b2b_d1", int'(lg_tx[p2 + 2 + C * (b + 1) + 2]), 1);
      end
    end else begin
      chk("b2b_window", p2, p1 + FRAME1 + 3);
    end

    // enable drops mid-frame
    push(0, 8'h5A);
    push(0, 8'h99);
    run_log(0, 1, 15);
    enable = 1'b0;
    run_log(0, 16, 120);
    chk("en_rd_cnt", count_of(1, 120), 1);
    chk("en_fd_cnt", count_of(2, 120), 1);
    chk("en_q_left", q0.size(), 1);
    enable = 1'b1;
    run_log(0, 1, 60);
    chk("en2_rd_cnt", count_of(1, 60), 1);
    chk("en2_fd_cnt", count_of(2, 60), 1);
    chk("en2_q_left", q0.size(), 0);
    for (int s = 0; s < 9; s++) begin
      logic [8:0] e99;
      e99 = 9'h132;
      chk("en2_sym", int'(lg_tx[3 + C * s + 2]), int'(e99[s]));
    end

    // Reset mid-frame during data bit 3
    push(0, 8'h3C);
    run_log(0, 1, 20);
    chk("pre_rst_busy", int'(busy_w[0]), 1);
    areset();
    cyc();
    run_log(0, 1, 50);
    chk("post_rst_tx", count_of(0, 50), 0);
    chk("post_rst_rd", count_of(1, 50), 0);
    chk("post_rst_busy", int'(busy_w[0]), 0);

`ifdef UART_TX_PARITY_EN
    push(1, 8'h07);
    run_log(1, 1, FRAME1 + 10);
    chk("par_odd", int'(lg_tx[3 + C * 9 + 2]), 0);
    chk("par_fd_at", nth_of(2, 1, FRAME1 + 10), 3 + FRAME1 - 1);
`endif

    // Random traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0 && q0.size() < 3) push(0, 8'($urandom));
      if ($urandom_range(0, 9) == 0 && q1.size() < 3) push(1, 8'($urandom));
      if ($urandom_range(0, 499) == 0) areset();
      cyc();
    end
    enable = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      cyc();
      done = (q0.size() == 0) && (q1.size() == 0) &&
             !cur0.busy && !cur1.busy;
    end
    chk("drain", int'(done), 1);
    chk("drain_busy0", int'(busy_w[0]), 0);
    chk("drain_busy1", int'(busy_w[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
